// File: rtl/pc_adder.sv
// PC increment and PC-relative branch-target unit for the 16-bit datapath.
// Define PC_ADDER_ALIGN_CHECK_EN to add the misalign / brMisalign outputs.
module pc_adder #(
   parameter int WIDTH = 16,
   parameter int INC   = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] pcIn,
   output logic [WIDTH-1:0] addOut,
   output logic             incCarry,
   input  logic [7:0]       brOff,
   input  logic             brLd,
   output logic [WIDTH-1:0] brAddr,
   output logic             brValid,
   output logic             brCarry
`ifdef PC_ADDER_ALIGN_CHECK_EN
   ,
   output logic             misalign,
   output logic             brMisalign
`endif
);

   localparam int SW = WIDTH + 2;

   logic [WIDTH:0]       inc_sum;
   logic signed [SW-1:0] offset_ext;
   logic signed [SW-1:0] target;
   logic                 target_wrap;

   assign inc_sum  = {1'b0, pcIn} + (WIDTH+1)'(INC);
   assign addOut   = inc_sum[WIDTH-1:0];
   assign incCarry = inc_sum[WIDTH];

   // Offset counts instruction words: sign-extend, then shift left by one.
   assign offset_ext = {{(SW-9){brOff[7]}}, brOff, 1'b0};
   assign target     = $signed({2'b00, addOut}) + offset_ext;

   // Negative sets the sign bit; overshooting the top sets bit WIDTH.
   assign target_wrap = target[SW-1] | target[WIDTH];

   // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         brAddr  <= '0;
         brValid <= 1'b0;
         brCarry <= 1'b0;
      end else if (brLd) begin
         brAddr  <= target[WIDTH-1:0];
         brValid <= 1'b1;
         brCarry <= target_wrap;
      end
   end

`ifdef PC_ADDER_ALIGN_CHECK_EN
   assign misalign = pcIn[0];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         brMisalign <= 1'b0;
      end else if (brLd) begin
         brMisalign <= pcIn[0];
      end
   end
`endif

endmodule

// File: tb/tb_pc_adder.sv
// Self-checking bench for pc_adder: directed cases plus randomized captures
// compared against an integer-arithmetic reference model.
module tb_pc_adder;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] pcIn;
   logic [15:0] addOut;
   logic        incCarry;
   logic [7:0]  brOff;
   logic        brLd;
   logic [15:0] brAddr;
   logic        brValid;
   logic        brCarry;
`ifdef PC_ADDER_ALIGN_CHECK_EN
   logic        misalign;
   logic        brMisalign;
   logic        m_mis;
`endif

   int checks   = 0;
   int failures = 0;

   // Reference model state for the registered outputs.
   int   m_addr;
   logic m_valid;
   logic m_carry;

   pc_adder #(.WIDTH(16), .INC(2)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .pcIn     (pcIn),
      .addOut   (addOut),
      .incCarry (incCarry),
      .brOff    (brOff),
      .brLd     (brLd),
      .brAddr   (brAddr),
      .brValid  (brValid),
      .brCarry  (brCarry)
`ifdef PC_ADDER_ALIGN_CHECK_EN
      ,
      .misalign   (misalign),
      .brMisalign (brMisalign)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int exp_add(input int pc);
      return (pc + 2) % 65536;
   endfunction

   function automatic int exp_target(input int pc, input logic [7:0] off);
      return exp_add(pc) + 2 * int'($signed(off));
   endfunction

   task automatic check_comb(input string tag);
      check({tag, "_add"}, 32'(addOut), 32'(exp_add(int'(pcIn))));
      check({tag, "_inc_carry"}, 32'(incCarry), 32'((int'(pcIn) + 2) > 65535));
   endtask

   task automatic check_regs(input string tag);
      check({tag, "_br_addr"}, 32'(brAddr), 32'(m_addr));
      check({tag, "_br_valid"}, 32'(brValid), 32'(m_valid));
      check({tag, "_br_carry"}, 32'(brCarry), 32'(m_carry));
`ifdef PC_ADDER_ALIGN_CHECK_EN
      check({tag, "_br_misalign"}, 32'(brMisalign), 32'(m_mis));
`endif
   endtask

   // Drive inputs on the falling edge, clock once, update the model, sample #1 later.
   task automatic cycle(input logic r, input int pc, input logic [7:0] off, input logic ld);
      int t;
      @(negedge clk);
      rst_n = r;
      pcIn  = 16'(pc);
      brOff = off;
      brLd  = ld;
      @(posedge clk);
      if (!r) begin
         m_addr  = 0;
         m_valid = 1'b0;
         m_carry = 1'b0;
`ifdef PC_ADDER_ALIGN_CHECK_EN
         m_mis   = 1'b0;
`endif
      end else if (ld) begin
         t       = exp_target(pc, off);
         m_addr  = ((t % 65536) + 65536) % 65536;
         m_valid = 1'b1;
         m_carry = (t < 0) || (t > 65535);
`ifdef PC_ADDER_ALIGN_CHECK_EN
         m_mis   = pc[0];
`endif
      end
      #1;
   endtask

   initial begin
      int pcs[7] = '{0, 2, 4, 1, 6, 300, 260};
      rst_n = 1'b0;
      pcIn  = '0;
      brOff = '0;
      brLd  = 1'b0;
      m_addr = 0;
      m_valid = 1'b0;
      m_carry = 1'b0;
`ifdef PC_ADDER_ALIGN_CHECK_EN
      m_mis = 1'b0;
`endif

      // Reset for two edges; combinational path still live.
      cycle(1'b0, 300, 8'd0, 1'b1);
      cycle(1'b0, 300, 8'd0, 1'b0);
      check_regs("reset");
      check("reset_add_302", 32'(addOut), 32'd302);

      // Sequential increment, no clock dependency.
      rst_n = 1'b1;
      for (int i = 0; i < 7; i++) begin
         pcIn = 16'(pcs[i]);
         #1;
         check_comb($sformatf("seq%0d", i));
         #19;
      end
      pcIn = 16'h0001;
      #1;
      check("odd_pc_add", 32'(addOut), 32'd3);

      // Wrap at the top of the address space.
      pcIn = 16'hFFFF;
      #1;
      check("wrap_ffff_add", 32'(addOut), 32'h0001);
      check("wrap_ffff_carry", 32'(incCarry), 32'd1);
      pcIn = 16'hFFFE;
      #1;
      check("wrap_fffe_add", 32'(addOut), 32'h0000);
      check("wrap_fffe_carry", 32'(incCarry), 32'd1);

      // Directed branch capture, then hold.
      cycle(1'b1, 100, 8'd5, 1'b1);
      check("br_100_p5_addr", 32'(brAddr), 32'd112);
      check_regs("br_100_p5");
      cycle(1'b1, 500, 8'd77, 1'b0);
      cycle(1'b1, 600, 8'd12, 1'b0);
      check("br_hold_addr", 32'(brAddr), 32'd112);
      check_regs("br_hold");

      // Negative offsets, with and without wrap below zero.
      cycle(1'b1, 4, 8'hFC, 1'b1);
      check("br_4_m4_addr", 32'(brAddr), 32'hFFFE);
      check("br_4_m4_carry", 32'(brCarry), 32'd1);
      cycle(1'b1, 20, 8'hFD, 1'b1);
      check("br_20_m3_addr", 32'(brAddr), 32'd16);
      check("br_20_m3_carry", 32'(brCarry), 32'd0);

      // Positive overflow past the top.
      cycle(1'b1, 16'hFFF0, 8'h7F, 1'b1);
      check_regs("br_top_wrap");

      // Reset and capture on the same edge: reset wins.
      cycle(1'b0, 100, 8'd5, 1'b1);
      check_regs("prio_reset");
      check("prio_valid", 32'(brValid), 32'd0);

      // Randomized captures, holds and occasional resets.
      for (int i = 0; i < 60; i++) begin
         logic r;
         r = ($urandom_range(0, 9) != 0);
         cycle(r, int'($urandom_range(0, 65535)), 8'($urandom), 1'($urandom));
         check_comb($sformatf("rnd%0d", i));
         check_regs($sformatf("rnd%0d", i));
      end

`ifdef PC_ADDER_ALIGN_CHECK_EN
      pcIn = 16'd1;
      #1;
      check("misalign_1", 32'(misalign), 32'd1);
      pcIn = 16'd2;
      #1;
      check("misalign_2", 32'(misalign), 32'd0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/pc_adder.md
# pc_adder

Program-counter increment and branch-target unit for the 16-bit CPE142 datapath. Combinationally produces the sequential next-PC (`pcIn + INC`) for the fetch mux. Also computes and registers a PC-relative branch target for the branch/jump stage. Sits between the PC register and the next-PC select mux.

## Interface

Parameters:
- `WIDTH`, default 16: PC width in bits.
- `INC`, default 2: sequential increment (bytes per instruction word).

Ports (one clock; reset is synchronous and active-low):
- `clk`, input, 1: rising-edge clock.
- `rst_n`, input, 1: synchronous active-low reset, sampled on `clk` rising edge.
- `pcIn`, input, WIDTH: current PC.
- `addOut`, output, WIDTH: combinational `pcIn + INC`, modulo 2^WIDTH.
- `incCarry`, output, 1: combinational carry-out of `pcIn + INC`.
- `brOff`, input, 8: signed branch offset, in instruction words.
- `brLd`, input, 1: capture-enable for the branch target.
- `brAddr`, output, WIDTH: registered branch target.
- `brValid`, output, 1: registered; `brAddr` holds a captured target.
- `brCarry`, output, 1: registered; target wrapped past either end of the address space.

## Operation

- `addOut = (pcIn + INC) mod 2^WIDTH`. This path is purely combinational, with no clock or reset dependency.
- `incCarry` = bit WIDTH of the (WIDTH+1)-bit sum `pcIn + INC`.
- Branch target computation: `T = addOut + (sign_extend(brOff) << 1)`.
  - The sum is formed at WIDTH+2 bits, signed.
  - `brAddr` receives `T mod 2^WIDTH`.
  - `brCarry` = 1 when `T < 0` or `T > 2^WIDTH − 1`.
- Each `clk` rising edge, in priority order:
  - `rst_n=0`: `brAddr←0`, `brValid←0`, `brCarry←0`.
  - else `brLd=1`: capture `brAddr`, `brCarry`; set `brValid←1`.
  - else: hold all registers. `brValid` stays 1 until reset.
- Odd `pcIn` is legal: `addOut` is simply `pcIn + INC` (e.g. 1 → 3). No alignment correction.
- `INC` must be less than 2^WIDTH. The offset shift is fixed at 1 regardless of `INC`.

## Timing

- `addOut` and `incCarry`: zero-cycle combinational latency from `pcIn`.
- `brAddr`, `brValid`, `brCarry`: 1-cycle latency. They reflect `pcIn`/`brOff` sampled at the edge where `brLd=1`.
- Reset values: `brAddr=0x0000`, `brValid=0`, `brCarry=0`. `addOut` and `incCarry` have no reset value; they track `pcIn` at all times.
- Reset asserted in the same cycle as `brLd`: reset wins.
- Reset mid-operation clears the registered outputs on that edge. The combinational outputs are unaffected.
- No handshake; `brLd` is a single-cycle strobe and may be held high to capture every cycle.

## Configuration

- `PC_ADDER_ALIGN_CHECK_EN`:
  - Defined: adds output `misalign` (1 bit, combinational) = `pcIn[0]`.
  - Defined: adds registered `brMisalign`, captured with `brAddr` as `pcIn[0]` and reset to 0.
  - Undefined: neither port exists; all other behaviour is identical.

## Test plan

- Sequential increment, stimulus applied every 20 time units with no clock dependency: `pcIn` = 0, 2, 4, 1, 6, 300, 260 → `addOut` = 2, 4, 6, 3, 8, 302, 262, with `incCarry=0` throughout.
- Wrap: `pcIn=0xFFFF` → `addOut=0x0001`, `incCarry=1`; `pcIn=0xFFFE` → `addOut=0x0000`, `incCarry=1`.
- Reset: `rst_n=0` for 2 edges after arbitrary captures → `brAddr=0`, `brValid=0`, `brCarry=0`. Meanwhile `pcIn=300` still gives `addOut=302`.
- Branch capture: `pcIn=100`, `brOff=+5`, `brLd=1` for one edge → next cycle `brAddr=112`, `brValid=1`, `brCarry=0`. Values hold after `brLd` drops.
- Negative and wrapping offsets:
  - `pcIn=4`, `brOff=−4` → `brAddr=0xFFFE`, `brCarry=1`.
  - `pcIn=20`, `brOff=−3` → `brAddr=16`, `brCarry=0`.
- Priority: `rst_n=0` with `brLd=1` on the same edge → registers cleared. With `PC_ADDER_ALIGN_CHECK_EN` defined: `pcIn=1` → `misalign=1`; `pcIn=2` → `misalign=0`.
